// File: rtl/regfile_alu_engine.sv
// Register file plus 8-op ALU with a 4-cycle RD/EX/WB sequencer.
// Ports: CLK/RST; cmd_* valid/ready command; host_* preload; dbg_* peek;
//        done/result/flag_* status.
module regfile_alu_engine #(
    parameter int WIDTH   = 32,
    parameter int NREGS   = 32,
    parameter bit R0_ZERO = 1'b1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [AW-1:0]    cmd_rd,
    input  logic [AW-1:0]    cmd_rs1,
    input  logic [AW-1:0]    cmd_rs2,
    input  logic             host_we,
    input  logic [AW-1:0]    host_addr,
    input  logic [WIDTH-1:0] host_wd,
    output logic             host_err,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_rd,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v
);

    localparam int SW  = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_EX,
        S_WB
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] regs [NREGS];

    logic [2:0]       op_q;
    logic [AW-1:0]    rd_q;
    logic [AW-1:0]    rs1_q;
    logic [AW-1:0]    rs2_q;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;

    logic accept;
    logic host_ok;
    logic host_rej;
    logic wb_en;
    logic host_wr_en;

    assign cmd_ready = (state == S_IDLE);
    assign accept    = cmd_valid & cmd_ready;

    // A command accepted on the same edge takes priority over the host.
    assign host_ok  = host_we & (state == S_IDLE) & ~accept;
    assign host_rej = host_we & ~host_ok;

    assign wb_en      = (state == S_WB) &
                        ~(R0_ZERO && rd_q == '0);
    assign host_wr_en = host_ok &
                        ~(R0_ZERO && host_addr == '0);

    assign dbg_rd = (R0_ZERO && dbg_addr == '0) ?
                    '0 : regs[dbg_addr];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (accept) state_nxt = S_RD;
            S_RD:    state_nxt = S_EX;
            S_EX:    state_nxt = S_WB;
            S_WB:    state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wb_en) begin
            regs[rd_q] <= result;
        end else if (host_wr_en) begin
            regs[host_addr] <= host_wd;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            op_q  <= '0;
            rd_q  <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
        end else if (accept) begin
            op_q  <= cmd_op;
            rd_q  <= cmd_rd;
            rs1_q <= cmd_rs1;
            rs2_q <= cmd_rs2;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            opa <= '0;
            opb <= '0;
        end else if (state == S_RD) begin
            opa <= (R0_ZERO && rs1_q == '0) ? '0 : regs[rs1_q];
            opb <= (R0_ZERO && rs2_q == '0) ? '0 : regs[rs2_q];
        end
    end

    // Shifts carry one extra bit so the last bit shifted out lands in
    // a fixed position (and is naturally 0 for a zero shift).
    logic [SW-1:0]    shamt;
    logic [WIDTH:0]   add_w;
    logic [WIDTH-1:0] sub_w;
    logic [WIDTH:0]   sll_w;
    logic [WIDTH:0]   srl_w;
    logic [WIDTH:0]   sra_w;

    assign shamt = opb[SW-1:0];
    assign add_w = {1'b0, opa} + {1'b0, opb};
    assign sub_w = opa - opb;
    assign sll_w = {1'b0, opa} << shamt;
    assign srl_w = {opa, 1'b0} >> shamt;
    assign sra_w = $signed({opa, 1'b0}) >>> shamt;

    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        unique case (op_q)
            3'b000: begin
                alu_res = add_w[MSB:0];
                alu_c   = add_w[WIDTH];
                alu_v   = (opa[MSB] == opb[MSB]) &
                          (alu_res[MSB] != opa[MSB]);
            end
            3'b001: begin
                alu_res = sub_w;
                alu_c   = (opa >= opb);
                alu_v   = (opa[MSB] != opb[MSB]) &
                          (alu_res[MSB] != opa[MSB]);
            end
            3'b010: begin
                alu_res = sll_w[MSB:0];
                alu_c   = sll_w[WIDTH];
            end
            3'b011: begin
                alu_res = srl_w[WIDTH:1];
                alu_c   = srl_w[0];
            end
            3'b100: begin
                alu_res = sra_w[WIDTH:1];
                alu_c   = sra_w[0];
            end
            3'b101:  alu_res = opa & opb;
            3'b110:  alu_res = opa | opb;
            3'b111:  alu_res = opa ^ opb;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            result <= '0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
        end else if (state == S_EX) begin
            result <= alu_res;
            flag_z <= (alu_res == '0);
            flag_n <= alu_res[MSB];
            flag_c <= alu_c;
            flag_v <= alu_v;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            done     <= 1'b0;
            host_err <= 1'b0;
        end else begin
            done     <= (state == S_WB);
            host_err <= host_rej;
        end
    end

endmodule

// File: tb/tb_regfile_alu_engine.sv
// Directed bench for regfile_alu_engine with a cycle-level reference model.
// Ports: none; drives the DUT and prints a single summary line.
module tb_regfile_alu_engine;

    logic        CLK;
    logic        RST;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [4:0]  cmd_rd;
    logic [4:0]  cmd_rs1;
    logic [4:0]  cmd_rs2;
    logic        host_we;
    logic [4:0]  host_addr;
    logic [31:0] host_wd;
    logic        host_err;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_rd;
    logic        done;
    logic [31:0] result;
    logic        flag_z, flag_n, flag_c, flag_v;

    regfile_alu_engine #(
        .WIDTH(32), .NREGS(32), .R0_ZERO(1'b1)
    ) dut (
        .CLK(CLK), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd),
        .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .host_we(host_we), .host_addr(host_addr),
        .host_wd(host_wd), .host_err(host_err),
        .dbg_addr(dbg_addr), .dbg_rd(dbg_rd),
        .done(done), .result(result),
        .flag_z(flag_z), .flag_n(flag_n),
        .flag_c(flag_c), .flag_v(flag_v)
    );

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, SLL = 3'd2,
                           SRL = 3'd3, SRA = 3'd4;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)",
                     nm, got, exp, $time);
        end
    endtask

    // ALU reference from plain integer arithmetic.
    function automatic void ref_alu(input logic [2:0] op,
                                    input logic [31:0] a,
                                    input logic [31:0] b,
                                    output logic [31:0] r,
                                    output logic c,
                                    output logic v);
        longint sa, sb, s;
        logic [63:0] u;
        logic [31:0] t;
        int sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b[4:0]);
        c = 1'b0;
        v = 1'b0;
        r = '0;
        case (op)
            3'd0: begin
                u = {32'd0, a} + {32'd0, b};
                r = u[31:0];
                c = u[32];
                s = sa + sb;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd1: begin
                r = a - b;
                c = (a >= b);
                s = sa - sb;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd2: begin
                r = a << sh;
                t = a >> (32 - sh);
                c = (sh != 0) && t[0];
            end
            3'd3, 3'd4: begin
                if (op == 3'd3) r = a >> sh;
                else            r = $signed(a) >>> sh;
                t = a >> (sh - 1);
                c = (sh != 0) && t[0];
            end
            3'd5: r = a & b;
            3'd6: r = a | b;
            default: r = a ^ b;
        endcase
    endfunction

    // Reference engine: m_age counts edges since a command was taken.
    int          m_age;
    logic        m_done, m_err;
    logic [31:0] m_res;
    logic [3:0]  m_f;
    logic [31:0] m_regs [32];
    logic [31:0] p_res;
    logic [3:0]  p_f;
    logic [4:0]  p_rd;

    always @(posedge CLK or posedge RST) begin
        logic [31:0] r;
        logic c, v, acc;
        if (RST) begin
            m_age  <= 0;
            m_done <= 1'b0;
            m_err  <= 1'b0;
            m_res  <= '0;
            m_f    <= '0;
            for (int i = 0; i < 32; i++) m_regs[i] <= '0;
        end else begin
            acc = (m_age == 0) && cmd_valid;
            m_done <= (m_age == 3);
            m_err  <= host_we && !(m_age == 0 && !acc);
            if (host_we && m_age == 0 && !acc && host_addr != 0)
                m_regs[host_addr] <= host_wd;
            case (m_age)
                0: if (acc) begin
                    ref_alu(cmd_op, m_regs[cmd_rs1], m_regs[cmd_rs2],
                            r, c, v);
                    p_res <= r;
                    p_f   <= {r == 0, r[31], c, v};
                    p_rd  <= cmd_rd;
                    m_age <= 1;
                end
                1: m_age <= 2;
                2: begin
                    m_res <= p_res;
                    m_f   <= p_f;
                    m_age <= 3;
                end
                default: begin
                    if (p_rd != 0) m_regs[p_rd] <= p_res;
                    m_age <= 0;
                end
            endcase
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("cmp_ready", cmd_ready, m_age == 0);
            check("cmp_done", done, m_done);
            check("cmp_host_err", host_err, m_err);
            check("cmp_result", result, m_res);
            check("cmp_flags", {flag_z, flag_n, flag_c, flag_v}, m_f);
            check("cmp_dbg", dbg_rd, m_regs[dbg_addr]);
        end
    end

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic host_write(input logic [4:0] a, input logic [31:0] d);
        host_we   = 1'b1;
        host_addr = a;
        host_wd   = d;
        step();
        host_we   = 1'b0;
    endtask

    task automatic dbg(input logic [4:0] a, input logic [31:0] exp,
                       input string nm);
        dbg_addr = a;
        #1;
        check(nm, dbg_rd, exp);
    endtask

    task automatic accept_cmd(input logic [2:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2);
        bit got;
        got = 0;
        cmd_valid = 1'b1;
        cmd_op  = op;
        cmd_rd  = rd;
        cmd_rs1 = rs1;
        cmd_rs2 = rs2;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready) begin
                got = 1;
                step();
                break;
            end
            step();
        end
        cmd_valid = 1'b0;
        if (!got) check("accept_timeout", 0, 1);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 10) begin
            step();
            lat++;
        end
        if (!done) check("done_timeout", 0, 1);
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2);
        int lat;
        accept_cmd(op, rd, rs1, rs2);
        wait_done(lat);
        check("done_latency", lat, 3);
    endtask

    task automatic flags(input logic [3:0] exp, input string nm);
        check(nm, {flag_z, flag_n, flag_c, flag_v}, exp);
    endtask

    initial begin
        int t1, t2, lat;
        bit got;
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t1, t2, lat;
        bit got;
        RST = 1'b1;
        cmd_valid = 0; cmd_op = 0; cmd_rd = 0; cmd_rs1 = 0; cmd_rs2 = 0;
        host_we = 0; host_addr = 0; host_wd = 0; dbg_addr = 0;
        repeat (3) @(posedge CLK);
        #2;
        RST = 1'b0;
        chk_en = 1;

        check("rst_ready", cmd_ready, 1);
        check("rst_result", result, 0);
        flags(4'b0000, "rst_flags");
        dbg(5'd5, 32'd0, "rst_reg");

        host_write(5'd10, 32'd10);
        host_write(5'd15, 32'd15);
        run_cmd(ADD, 5'd20, 5'd10, 5'd15);
        dbg(5'd20, 32'd25, "add_r20");
        flags(4'b0000, "add_flags");

        host_write(5'd10, 32'd20);
        run_cmd(SUB, 5'd20, 5'd10, 5'd15);
        dbg(5'd20, 32'd5, "sub_r20");
        flags(4'b0010, "sub_flags");

        host_write(5'd10, 32'd31);
        host_write(5'd15, 32'd2);
        run_cmd(SLL, 5'd21, 5'd10, 5'd15);
        check("sll_res", result, 32'd124);
        flags(4'b0000, "sll_flags");
        run_cmd(SRL, 5'd21, 5'd10, 5'd15);
        check("srl_res", result, 32'd7);
        flags(4'b0010, "srl_flags");
        host_write(5'd10, 32'h8000_0000);
        host_write(5'd15, 32'd4);
        run_cmd(SRA, 5'd22, 5'd10, 5'd15);
        dbg(5'd22, 32'hF800_0000, "sra_r22");
        flags(4'b0100, "sra_flags");

        host_write(5'd1, 32'hFFFF_FFFF);
        host_write(5'd2, 32'd1);
        run_cmd(ADD, 5'd3, 5'd1, 5'd2);
        check("wrap_res", result, 32'd0);
        flags(4'b1010, "wrap_flags");
        host_write(5'd1, 32'h7FFF_FFFF);
        run_cmd(ADD, 5'd3, 5'd1, 5'd2);
        check("ovf_res", result, 32'h8000_0000);
        flags(4'b0101, "ovf_flags");
        host_write(5'd1, 32'd5);
        host_write(5'd2, 32'd7);
        run_cmd(SUB, 5'd3, 5'd1, 5'd2);
        check("borrow_res", result, 32'hFFFF_FFFE);
        flags(4'b0100, "borrow_flags");

        run_cmd(ADD, 5'd0, 5'd10, 5'd15);
        dbg(5'd0, 32'd0, "r0_after_add");
        host_write(5'd0, 32'h55);
        check("r0_host_err", host_err, 0);
        dbg(5'd0, 32'd0, "r0_after_host");
        run_cmd(ADD, 5'd1, 5'd0, 5'd0);
        dbg(5'd1, 32'd0, "r0_sum");
        flags(4'b1000, "r0_flags");

        host_write(5'd1, 32'd100);
        host_write(5'd2, 32'd23);
        cmd_valid = 1'b1;
        cmd_op = ADD; cmd_rd = 5'd3; cmd_rs1 = 5'd1; cmd_rs2 = 5'd2;
        t1 = 0; t2 = 0; got = 0;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready) begin t1 = cyc; got = 1; step(); break; end
            step();
        end
        cmd_rd = 5'd4; cmd_rs1 = 5'd3; cmd_rs2 = 5'd3;
        for (int i = 0; i < 20 && got; i++) begin
            if (cmd_ready) begin t2 = cyc; step(); break; end
            step();
        end
        cmd_valid = 1'b0;
        check("b2b_spacing", t2 - t1, 4);
        wait_done(lat);
        dbg(5'd3, 32'd123, "b2b_r3");
        dbg(5'd4, 32'd246, "b2b_r4");

        host_write(5'd5, 32'h1234);
        accept_cmd(ADD, 5'd6, 5'd1, 5'd2);
        step();
        host_we = 1'b1; host_addr = 5'd5; host_wd = 32'hDEAD;
        step();
        host_we = 1'b0;
        check("busy_host_err", host_err, 1);
        wait_done(lat);
        dbg(5'd5, 32'h1234, "busy_host_keep");

        host_write(5'd10, 32'd3);
        host_write(5'd15, 32'd4);
        accept_cmd(ADD, 5'd7, 5'd10, 5'd15);
        step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("rst_no_done", done, 0);
            step();
        end
        dbg(5'd7, 32'd0, "rst_r7");
        check("rst_mid_result", result, 0);
        flags(4'b0000, "rst_mid_flags");
        check("rst_mid_ready", cmd_ready, 1);

        host_write(5'd10, 32'd9);
        host_write(5'd15, 32'd8);
        run_cmd(ADD, 5'd7, 5'd10, 5'd15);
        dbg(5'd7, 32'd17, "post_rst_r7");

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_alu_engine.md
Name: regfile_alu_engine

Overview:
Parametrised register-file-plus-ALU execution engine: a multi-register datapath with an internal sequencer. It accepts register-register commands over a valid/ready handshake, reads two source registers, computes an 8-op ALU result with flags, and writes the result back. A host port preloads and inspects registers. It is the integrated, self-sequencing successor to the separate register file and 4-op ALU.

Parameters:
WIDTH, 32, data word width in bits (>=8, power of two)
NREGS, 32, number of registers (power of two, >=4); AW = $clog2(NREGS)
R0_ZERO, 1, 1: register 0 reads 0 and ignores writes; 0: register 0 is ordinary

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  engine can accept a command
cmd_op  in  3  000 ADD, 001 SUB, 010 SLL, 011 SRL, 100 SRA, 101 AND, 110 OR, 111 XOR
cmd_rd  in  AW  destination register
cmd_rs1  in  AW  source A register
cmd_rs2  in  AW  source B register
host_we  in  1  host write strobe
host_addr  in  AW  host write address
host_wd  in  WIDTH  host write data
host_err  out  1  one-cycle pulse: host write rejected
dbg_addr  in  AW  debug read address
dbg_rd  out  WIDTH  combinational contents of register dbg_addr
done  out  1  one-cycle pulse: writeback committed
result  out  WIDTH  last computed result, held until the next EX
flag_z, flag_n, flag_c, flag_v  out  1 each  zero/negative/carry/overflow of last result, held

Behaviour:
- Reset (async): FSM to IDLE; all registers, result, flags, done and host_err cleared to 0. No command is accepted while RST is high. Reset mid-command aborts it with no writeback and no done pulse.
- cmd_ready = (state==IDLE). The command is accepted on the rising edge where cmd_valid & cmd_ready; op/rd/rs1/rs2 are latched at that edge.
- FSM: IDLE -accept-> RD -> EX -> WB -> IDLE, one cycle each, unconditional after accept.
- RD edge: latch opA=reg[rs1] and opB=reg[rs2] (0 for r0 when R0_ZERO=1).
- EX edge: register result and all four flags.
- WB edge: write result to reg[rd] (discarded if rd==0 and R0_ZERO=1). done is high for exactly the cycle after the WB edge, and cmd_ready is high in that same cycle.
- Throughput: one command per 4 cycles. Back-to-back accept is possible on the edge ending the done cycle; the next RD reads the updated reg[rd].
- Arithmetic: shamt = opB[log2(WIDTH)-1:0], and the upper bits of opB are ignored. SRA sign-extends. SLL/SRL fill with zeros.
- Flags: Z = (result==0); N = result[WIDTH-1].
- C flag: ADD carry-out; SUB = no borrow (opA >= opB unsigned); shifts = last bit shifted out, 0 when shamt==0; logic ops = 0.
- V flag: signed overflow for ADD/SUB; 0 otherwise.
- Host write: performed on the edge where host_we=1 and state==IDLE, with no acceptance on that edge. If a command is accepted on the same edge, the command wins and the host write is rejected.
- Rejected host write (host_we while state!=IDLE, or while a command is accepted): register unchanged, host_err pulses high for the next cycle.
- A host write to r0 with R0_ZERO=1 is silently discarded; host_err is not raised.
- dbg_rd is combinational and reflects committed contents; a write shows on dbg_rd after its edge.

Test Plan:
- Load r10=10, r15=15; ADD rd=20 -> done 4 cycles after accept, r20=25, Z=0 C=0 V=0; then SUB r10=20,r15=15 -> r20=5, C=1.
- r10=31, r15=2: SLL -> 124, C=0; SRL -> 7, C=1; SRA with r10=0x80000000, r15=4 -> 0xF8000000, N=1.
- Flag edges: 0xFFFFFFFF+1 -> 0, Z=1 C=1 V=0; 0x7FFFFFFF+1 -> 0x80000000, V=1 N=1; 5-7 -> 0xFFFFFFFE, C=0 N=1.
- R0_ZERO: ADD rd=0 -> r0 stays 0; host write r0=0x55 -> dbg_rd(0)=0, host_err=0; ADD r1=r0+r0 -> 0, Z=1.
- Handshake: cmd_valid held high with two queued commands -> accepts exactly 4 cycles apart; the second reads the first's rd (r3=r1+r2, then r4=r3+r3 gives 2x the sum). host_we during EX -> host_err pulse, register unchanged.
- Assert RST during EX of ADD rd=7 -> no done, r7=0, result and flags 0, FSM IDLE after release; the next command runs normally.
